// File: rtl/wbu_regfile.sv
// rtl/wbu_regfile.sv - writeback buffer, GPR file, retire counter and ebreak halt
// Optional WBU_BYPASS_EN: read ports see the committing result during its commit cycle.
module wbu_regfile #(
   parameter int XLEN   = 32,
   parameter int NR_REG = 32,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic             in_wen,
   input  logic [XLEN-1:0]  in_result,
   input  logic             in_halt,
   input  logic [4:0]       rs1_addr,
   output logic [XLEN-1:0]  rs1_data,
   input  logic [4:0]       rs2_addr,
   output logic [XLEN-1:0]  rs2_data,
   output logic             commit_valid,
   output logic [4:0]       commit_rd,
   output logic [XLEN-1:0]  commit_data,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             halted
);

   localparam int         AW       = (NR_REG > 1) ? $clog2(NR_REG) : 1;
   localparam logic [5:0] NR_REG_L = 6'(NR_REG);

   typedef enum logic [1:0] {IDLE, COMMIT, HALTED} state_t;

   state_t           state_q, state_d;
   logic [4:0]       buf_rd_q;
   logic             buf_wen_q;
   logic             buf_halt_q;
   logic [XLEN-1:0]  buf_result_q;
   logic [XLEN-1:0]  gpr_q [NR_REG];
   logic [CNT_W-1:0] cnt_q;
   logic             xfer;
   logic             commit;
   logic             gpr_we;
   logic [4:0]       raddr [2];
   logic [XLEN-1:0]  rdata [2];

   assign in_ready     = (state_q != HALTED);
   assign xfer         = in_valid && in_ready;
   assign commit       = (state_q == COMMIT);
   // x0 and unimplemented registers still retire, they just never reach the array
   assign gpr_we       = commit && buf_wen_q && (buf_rd_q != 5'd0) && ({1'b0, buf_rd_q} < NR_REG_L);

   assign commit_valid = commit;
   assign commit_rd    = buf_rd_q;
   assign commit_data  = buf_result_q;
   assign retire_cnt   = cnt_q;
   assign halted       = (state_q == HALTED);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (xfer) state_d = COMMIT;
         end
         COMMIT: begin
            if (buf_halt_q)  state_d = HALTED;
            else if (xfer)   state_d = COMMIT;
            else             state_d = IDLE;
         end
         default: state_d = HALTED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         buf_rd_q     <= 5'd0;
         buf_wen_q    <= 1'b0;
         buf_halt_q   <= 1'b0;
         buf_result_q <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < NR_REG; i++) gpr_q[i] <= '0;
      end else begin
         state_q <= state_d;
         // a transfer landing with a halt commit is latched but never committed
         if (xfer) begin
            buf_rd_q     <= in_rd;
            buf_wen_q    <= in_wen;
            buf_halt_q   <= in_halt;
            buf_result_q <= in_result;
         end
         if (commit) cnt_q <= cnt_q + CNT_W'(1);
         if (gpr_we) gpr_q[buf_rd_q[AW-1:0]] <= buf_result_q;
      end
   end

   assign raddr[0] = rs1_addr;
   assign raddr[1] = rs2_addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         if ((raddr[p] != 5'd0) && ({1'b0, raddr[p]} < NR_REG_L))
            rdata[p] = gpr_q[raddr[p][AW-1:0]];
`ifdef WBU_BYPASS_EN
         if (gpr_we && (raddr[p] == buf_rd_q))
            rdata[p] = buf_result_q;
`else
`endif
      end
   end

   assign rs1_data = rdata[0];
   assign rs2_data = rdata[1];

endmodule

// File: tb/tb_wbu_regfile.sv
// tb/tb_wbu_regfile.sv - self-checking bench for wbu_regfile
// Directed vector table, hand-written corner sequences and a randomized reference-model phase.
module tb_wbu_regfile;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_rd = 5'd0;
   logic        in_wen = 1'b0;
   logic [31:0] in_result = 32'd0;
   logic        in_halt = 1'b0;
   logic [4:0]  rs1_addr = 5'd0;
   logic [31:0] rs1_data;
   logic [4:0]  rs2_addr = 5'd0;
   logic [31:0] rs2_data;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic [31:0] retire_cnt;
   logic        halted;

   int n_cmp = 0;
   int n_bad = 0;

   wbu_regfile #(.XLEN(32), .NR_REG(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
      .in_result(in_result), .in_halt(in_halt),
      .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
      .retire_cnt(retire_cnt), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] res;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic        cv;
      logic [4:0]  crd;
      logic [31:0] cdata;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] cnt;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] res;
      logic        halt;
   } ent_t;

   vec_t        tbl [11];
   logic [31:0] m_gpr [32];
   logic [31:0] m_cnt;
   bit          m_halt;
   ent_t        pend [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                        input logic [31:0] res, input logic halt);
      in_valid  = v;
      in_rd     = rd;
      in_wen    = wen;
      in_result = res;
      in_halt   = halt;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [31:0] val;
      val = (a == 5'd0) ? 32'd0 : m_gpr[a];
`ifdef WBU_BYPASS_EN
      if (pend.size() > 0 && pend[0].wen && pend[0].rd != 5'd0 && pend[0].rd == a)
         val = pend[0].res;
`else
`endif
      return val;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_cnt  = 32'd0;
      m_halt = 1'b0;
      pend.delete();
   endtask

   // Advance the reference model across one rising edge given the inputs presented.
   task automatic m_edge();
      bit   acc;
      bit   stop;
      ent_t e;
      acc  = in_valid && !m_halt;
      stop = 1'b0;
      if (pend.size() > 0) begin
         e = pend.pop_front();
         if (e.wen && e.rd != 5'd0) m_gpr[e.rd] = e.res;
         m_cnt = m_cnt + 32'd1;
         if (e.halt) begin
            m_halt = 1'b1;
            stop   = 1'b1;
         end
      end
      if (acc && !stop) pend.push_back('{in_rd, in_wen, in_result, in_halt});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
      #12;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      tbl[0]  = '{1'b1, 5'd5, 1'b1, 32'h1234,     5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,    32'h0,    32'd0};
      tbl[1]  = '{1'b0, 5'd0, 1'b0, 32'h0,        5'd6, 5'd0, 1'b1, 5'd5, 32'h1234,     32'h0,    32'h0,    32'd0};
      tbl[2]  = '{1'b1, 5'd0, 1'b1, 32'hFFFFFFFF, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        32'h1234, 32'h0,    32'd1};
      tbl[3]  = '{1'b1, 5'd7, 1'b0, 32'hAA,       5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0,    32'h0,    32'd1};
      tbl[4]  = '{1'b0, 5'd0, 1'b0, 32'h0,        5'd7, 5'd5, 1'b1, 5'd7, 32'hAA,       32'h0,    32'h1234, 32'd2};
      tbl[5]  = '{1'b1, 5'd1, 1'b1, 32'h1,        5'd7, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,    32'h0,    32'd3};
      tbl[6]  = '{1'b1, 5'd2, 1'b1, 32'h2,        5'd5, 5'd0, 1'b1, 5'd1, 32'h1,        32'h1234, 32'h0,    32'd3};
      tbl[7]  = '{1'b1, 5'd3, 1'b1, 32'h3,        5'd1, 5'd0, 1'b1, 5'd2, 32'h2,        32'h1,    32'h0,    32'd4};
      tbl[8]  = '{1'b1, 5'd4, 1'b1, 32'h4,        5'd2, 5'd0, 1'b1, 5'd3, 32'h3,        32'h2,    32'h0,    32'd5};
      tbl[9]  = '{1'b0, 5'd0, 1'b0, 32'h0,        5'd3, 5'd2, 1'b1, 5'd4, 32'h4,        32'h3,    32'h2,    32'd6};
      tbl[10] = '{1'b0, 5'd0, 1'b0, 32'h0,        5'd4, 5'd1, 1'b0, 5'd0, 32'h0,        32'h4,    32'h1,    32'd7};

      // reset state
      do_reset();
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         chk("reset_rs1", rs1_data, 32'd0);
         chk("reset_rs2", rs2_data, 32'd0);
      end
      chk("reset_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_halted", {31'd0, halted}, 32'd0);
      chk("reset_cnt", retire_cnt, 32'd0);
      chk("reset_cv", {31'd0, commit_valid}, 32'd0);

      // directed vectors: single write, x0 / wen=0, back-to-back
      for (int r = 0; r < 11; r++) begin
         drive(tbl[r].v, tbl[r].rd, tbl[r].wen, tbl[r].res, 1'b0);
         rs1_addr = tbl[r].a1;
         rs2_addr = tbl[r].a2;
         #1;
         chk($sformatf("vec%0d_ready", r), {31'd0, in_ready}, 32'd1);
         chk($sformatf("vec%0d_cv", r), {31'd0, commit_valid}, {31'd0, tbl[r].cv});
         if (tbl[r].cv) begin
            chk($sformatf("vec%0d_crd", r), {27'd0, commit_rd}, {27'd0, tbl[r].crd});
            chk($sformatf("vec%0d_cdata", r), commit_data, tbl[r].cdata);
         end
         chk($sformatf("vec%0d_rs1", r), rs1_data, tbl[r].d1);
         chk($sformatf("vec%0d_rs2", r), rs2_data, tbl[r].d2);
         chk($sformatf("vec%0d_cnt", r), retire_cnt, tbl[r].cnt);
         tick();
      end

      // dependent read during the commit cycle
      drive(1'b1, 5'd3, 1'b1, 32'h99, 1'b0);
      rs2_addr = 5'd3;
      tick();
      drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
      #1;
`ifdef WBU_BYPASS_EN
      chk("bypass_rs2", rs2_data, 32'h99);
`else
      chk("bypass_rs2", rs2_data, 32'h3);
`endif
      tick();
      chk("bypass_after_rs2", rs2_data, 32'h99);
      chk("bypass_cnt", retire_cnt, 32'd8);

      // randomized phase against the reference model
      do_reset();
      m_reset();
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom, 1'b0);
         rs1_addr = 5'($urandom);
         rs2_addr = ($urandom_range(0, 1) == 1 && pend.size() > 0) ? pend[0].rd : 5'($urandom);
         #1;
         chk("rnd_ready", {31'd0, in_ready}, {31'd0, !m_halt});
         chk("rnd_cv", {31'd0, commit_valid}, (pend.size() > 0) ? 32'd1 : 32'd0);
         if (pend.size() > 0) begin
            chk("rnd_crd", {27'd0, commit_rd}, {27'd0, pend[0].rd});
            chk("rnd_cdata", commit_data, pend[0].res);
         end
         chk("rnd_rs1", rs1_data, m_read(rs1_addr));
         chk("rnd_rs2", rs2_data, m_read(rs2_addr));
         chk("rnd_cnt", retire_cnt, m_cnt);
         @(posedge clk);
         m_edge();
         #1;
      end

      // reset in the middle of a commit cycle discards the entry
      drive(1'b1, 5'd9, 1'b1, 32'h77, 1'b0);
      rs1_addr = 5'd9;
      tick();
      drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
      #1;
      chk("midrst_cv_before", {31'd0, commit_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_cv", {31'd0, commit_valid}, 32'd0);
      chk("midrst_cnt", retire_cnt, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("midrst_x9", rs1_data, 32'd0);
      chk("midrst_cnt_after", retire_cnt, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);

      // halt: ebreak commits, the following transfer is dropped
      drive(1'b1, 5'd10, 1'b1, 32'h55, 1'b1);
      rs1_addr = 5'd10;
      rs2_addr = 5'd11;
      tick();
      drive(1'b1, 5'd11, 1'b1, 32'hBB, 1'b0);
      #1;
      chk("halt_ready_commit", {31'd0, in_ready}, 32'd1);
      chk("halt_cv", {31'd0, commit_valid}, 32'd1);
      chk("halt_crd", {27'd0, commit_rd}, 32'd10);
      chk("halt_not_yet", {31'd0, halted}, 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("halt_halted", {31'd0, halted}, 32'd1);
         chk("halt_ready", {31'd0, in_ready}, 32'd0);
         chk("halt_cv_off", {31'd0, commit_valid}, 32'd0);
         chk("halt_x10", rs1_data, 32'h55);
         chk("halt_x11", rs2_data, 32'd0);
         chk("halt_cnt", retire_cnt, 32'd1);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("halt_rst_halted", {31'd0, halted}, 32'd0);
      chk("halt_rst_x10", rs1_data, 32'd0);
      chk("halt_rst_cnt", retire_cnt, 32'd0);
      drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("halt_rst_ready", {31'd0, in_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
